// File: rtl/ps2_rx_decoder.sv
// rtl/ps2_rx_decoder.sv - PS/2 receive decoder: conditioning, frame FSM, key assembly, optional byte FIFO.
// Optional byte FIFO is built only when PS2_RX_FIFO_EN is defined.
module ps2_rx_decoder #(
   parameter int FILTER    = 4,
   parameter int TIMEOUT   = 4096,
   parameter int FIFO_BITS = 3
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [7:0]  rx_byte,
   output logic        rx_valid,
   output logic [10:0] ps2_key,
   output logic        parity_err,
   output logic        frame_err,
   output logic        timeout_err,
   output logic [7:0]  err_cnt,
   input  logic        fifo_rd,
   output logic [7:0]  fifo_dout,
   output logic        fifo_empty,
   output logic        fifo_full,
   output logic        fifo_ovf
);

   localparam int FW = $clog2(FILTER + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

   logic [1:0]    clk_sync_q, data_sync_q;
   logic          clk_f_q, clk_f_d, data_f_q, data_f_d;
   logic [FW-1:0] clk_cnt_q, clk_cnt_d, data_cnt_q, data_cnt_d;
   logic          fall;

   state_t        state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [7:0]    rx_byte_q, rx_byte_d;
   logic          rx_valid_q, rx_valid_d;
   logic          perr_q, perr_d, ferr_q, ferr_d, terr_q, terr_d;
   logic          err_any;
   logic [7:0]    err_cnt_q;
   logic          ext_q, ext_d, rel_q, rel_d;
   logic [10:0]   key_q, key_d;

   // Synchronizers reset to the idle-high line level so reset never fakes an edge.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         clk_sync_q  <= 2'b11;
         data_sync_q <= 2'b11;
         clk_f_q     <= 1'b1;
         data_f_q    <= 1'b1;
         clk_cnt_q   <= '0;
         data_cnt_q  <= '0;
      end else begin
         clk_sync_q  <= {clk_sync_q[0], ps2_clk};
         data_sync_q <= {data_sync_q[0], ps2_data};
         clk_f_q     <= clk_f_d;
         data_f_q    <= data_f_d;
         clk_cnt_q   <= clk_cnt_d;
         data_cnt_q  <= data_cnt_d;
      end
   end

   always_comb begin
      clk_f_d    = clk_f_q;
      clk_cnt_d  = '0;
      data_f_d   = data_f_q;
      data_cnt_d = '0;
      if (clk_sync_q[1] != clk_f_q) begin
         if (clk_cnt_q == FW'(FILTER - 1)) clk_f_d = clk_sync_q[1];
         else clk_cnt_d = clk_cnt_q + 1'b1;
      end
      if (data_sync_q[1] != data_f_q) begin
         if (data_cnt_q == FW'(FILTER - 1)) data_f_d = data_sync_q[1];
         else data_cnt_d = data_cnt_q + 1'b1;
      end
   end

   assign fall = clk_f_q & ~clk_f_d;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q    <= S_IDLE;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         tmo_q      <= '0;
         rx_byte_q  <= '0;
         rx_valid_q <= 1'b0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         terr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         tmo_q      <= tmo_d;
         rx_byte_q  <= rx_byte_d;
         rx_valid_q <= rx_valid_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         terr_q     <= terr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      rx_byte_d  = rx_byte_q;
      rx_valid_d = 1'b0;
      perr_d     = 1'b0;
      ferr_d     = 1'b0;
      terr_d     = 1'b0;
      tmo_d      = (state_q == S_IDLE || fall) ? '0 : tmo_q + 1'b1;
      if (state_q != S_IDLE && !fall && tmo_q == TW'(TIMEOUT - 1)) begin
         terr_d  = 1'b1;
         state_d = S_IDLE;
         tmo_d   = '0;
      end else if (fall) begin
         case (state_q)
            S_IDLE: begin
               if (!data_f_q) begin
                  state_d   = S_DATA;
                  bit_cnt_d = '0;
               end
            end
            S_DATA: begin
               shift_d   = {data_f_q, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == 3'd7) state_d = S_PARITY;
            end
            S_PARITY: begin
               if (^{shift_q, data_f_q}) state_d = S_STOP;
               else begin
                  perr_d  = 1'b1;
                  state_d = S_IDLE;
               end
            end
            S_STOP: begin
               state_d = S_IDLE;
               if (data_f_q) begin
                  rx_byte_d  = shift_q;
                  rx_valid_d = 1'b1;
               end else begin
                  ferr_d = 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign err_any = perr_q | ferr_q | terr_q;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         err_cnt_q <= '0;
         ext_q     <= 1'b0;
         rel_q     <= 1'b0;
         key_q     <= '0;
      end else begin
         if (err_any && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 1'b1;
         ext_q <= ext_d;
         rel_q <= rel_d;
         key_q <= key_d;
      end
   end

   // E0/F0 are prefixes latched until the next plain code; E1 never forms an event.
   always_comb begin
      ext_d = ext_q;
      rel_d = rel_q;
      key_d = key_q;
      if (rx_valid_q) begin
         case (rx_byte_q)
            8'hE0: ext_d = 1'b1;
            8'hF0: rel_d = 1'b1;
            8'hE1: ;
            default: begin
               key_d = {~key_q[10], ~rel_q, ext_q, rx_byte_q};
               ext_d = 1'b0;
               rel_d = 1'b0;
            end
         endcase
      end else if (err_any) begin
         ext_d = 1'b0;
         rel_d = 1'b0;
      end
   end

   assign rx_byte     = rx_byte_q;
   assign rx_valid    = rx_valid_q;
   assign ps2_key     = key_q;
   assign parity_err  = perr_q;
   assign frame_err   = ferr_q;
   assign timeout_err = terr_q;
   assign err_cnt     = err_cnt_q;

`ifdef PS2_RX_FIFO_EN
   localparam int DEPTH = 1 << FIFO_BITS;

   logic [7:0]           mem_q [DEPTH];
   logic [FIFO_BITS-1:0] wr_ptr_q, rd_ptr_q;
   logic [FIFO_BITS:0]   count_q;
   logic                 ovf_q;
   logic                 rd_ok, wr_ok;

   // A full FIFO still accepts a write when a pop frees the slot in the same cycle.
   assign rd_ok = fifo_rd && (count_q != '0);
   assign wr_ok = rx_valid_q && ((count_q != (FIFO_BITS+1)'(DEPTH)) || rd_ok);

   always_ff @(posedge clk_sys) begin
      if (wr_ok) mem_q[wr_ptr_q] <= rx_byte_q;
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
         if (wr_ok && !rd_ok) count_q <= count_q + 1'b1;
         else if (rd_ok && !wr_ok) count_q <= count_q - 1'b1;
         if (rx_valid_q && !wr_ok) ovf_q <= 1'b1;
      end
   end

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == (FIFO_BITS+1)'(DEPTH));
   assign fifo_ovf   = ovf_q;
   assign fifo_dout  = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
`else
   logic unused_fifo_rd;
   assign unused_fifo_rd = fifo_rd;
   assign fifo_empty     = 1'b1;
   assign fifo_full      = 1'b0;
   assign fifo_ovf       = 1'b0;
   assign fifo_dout      = 8'h00;
`endif

endmodule
